// File: rtl/vlan_ingress_filter.sv
// 802.1Q ingress filter: buffers each frame until word 3 classifies it, then forwards, strips or drops it.
// Optional drop counters are built when VLAN_INGRESS_COUNTERS_EN is defined.
module vlan_ingress_filter #(
   parameter int          BUF_DEPTH = 8,
   parameter logic [15:0] TPID      = 16'h8100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] port_vlan,
   input  logic        port_drop_tagged,
   input  logic        port_drop_untagged,
   input  logic        rx_valid,
   input  logic        rx_start,
   input  logic        rx_last,
   input  logic [2:0]  rx_bytes_valid,
   input  logic [31:0] rx_data,
   output logic        tx_valid,
   output logic        tx_start,
   output logic        tx_last,
   output logic [2:0]  tx_bytes_valid,
   output logic [31:0] tx_data,
   output logic [11:0] tx_vlan
`ifdef VLAN_INGRESS_COUNTERS_EN
   ,
   output logic [31:0] drop_count_tagged,
   output logic [31:0] drop_count_untagged,
   output logic [31:0] drop_count_malformed
`endif
);

   localparam int AW = $clog2(BUF_DEPTH);

   typedef struct packed {
      logic        start;
      logic        last;
      logic [2:0]  bytes;
      logic        tag_word;
      logic [31:0] data;
   } buf_word_t;

   typedef struct packed {
      logic        drop;
      logic        strip;
      logic [11:0] vlan;
   } verdict_t;

   buf_word_t   buf_mem [BUF_DEPTH];
   verdict_t    vf_mem  [4];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [1:0]  vf_wr_q, vf_rd_q;
   logic [2:0]  vf_cnt_q;
   logic        open_q, decided_q, in_frame_q;
   logic [2:0]  idx_q;
   logic [11:0] vlan_q;
   logic        drop_tagged_q, drop_untagged_q;
   logic        tx_valid_q, tx_start_q, tx_last_q;
   logic [2:0]  tx_bytes_q;
   logic [31:0] tx_data_q;
   logic [11:0] tx_vlan_q;

   // Write side: words outside an open frame (e.g. right after reset) are ignored.
   logic       wr_en, is_w3, runt_end, trunc, tag_hit, vid_tagged, malformed_b;
   logic       push_b, decided_d;
   logic [2:0] cur_idx;
   logic [1:0] push_n;
   verdict_t   va, vb;

   assign wr_en       = rx_valid && (rx_start || open_q);
   assign cur_idx     = rx_start ? 3'd0 : idx_q;
   assign trunc       = wr_en && rx_start && open_q && !decided_q;
   assign is_w3       = wr_en && (cur_idx == 3'd3);
   assign runt_end    = wr_en && rx_last && (cur_idx < 3'd3);
   assign tag_hit     = (rx_data[31:16] == TPID);
   assign vid_tagged  = tag_hit && (rx_data[11:0] != 12'd0);
   // A 16-byte frame whose tag would be stripped has nothing left to forward.
   assign malformed_b = runt_end || (is_w3 && rx_last && ((rx_bytes_valid != 3'd4) || tag_hit));
   assign push_b      = is_w3 || runt_end;
   assign push_n      = {1'b0, trunc} + {1'b0, push_b};
   assign decided_d   = (rx_start ? 1'b0 : decided_q) || push_b;

   always_comb begin
      va.drop  = 1'b1;
      va.strip = 1'b0;
      va.vlan  = 12'd0;
      vb.drop  = malformed_b || (vid_tagged ? drop_tagged_q : drop_untagged_q);
      vb.strip = tag_hit;
      vb.vlan  = vid_tagged ? rx_data[11:0] : vlan_q;
   end

   // Read side
   buf_word_t head;
   verdict_t  vhead;
   logic      buf_empty, buf_full, vf_empty, close_frame, rd_pop, vf_pop, emit;

   assign head        = buf_mem[rd_ptr_q[AW-1:0]];
   assign vhead       = vf_mem[vf_rd_q];
   assign buf_empty   = (wr_ptr_q == rd_ptr_q);
   assign buf_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign vf_empty    = (vf_cnt_q == 3'd0);
   // A start word reached mid-frame means the frame was truncated: retire its verdict without a word.
   assign close_frame = !buf_empty && head.start && in_frame_q;
   assign rd_pop      = !buf_empty && !close_frame && !(head.start && vf_empty);
   assign vf_pop      = close_frame || (rd_pop && head.last);
   assign emit        = rd_pop && !vhead.drop && !(head.tag_word && vhead.strip);

   // NOTE: the storage arrays carry no reset; pointers and counts alone define their contents.
   always_ff @(posedge clk) begin
      if (wr_en)
         buf_mem[wr_ptr_q[AW-1:0]] <= '{start: rx_start, last: rx_last, bytes: rx_bytes_valid,
                                        tag_word: (cur_idx == 3'd3), data: rx_data};
      if (trunc)
         vf_mem[vf_wr_q] <= va;
      if (push_b)
         vf_mem[vf_wr_q + {1'b0, trunc}] <= vb;
   end

   // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         vf_wr_q         <= '0;
         vf_rd_q         <= '0;
         vf_cnt_q        <= '0;
         open_q          <= 1'b0;
         decided_q       <= 1'b0;
         idx_q           <= '0;
         in_frame_q      <= 1'b0;
         vlan_q          <= '0;
         drop_tagged_q   <= 1'b0;
         drop_untagged_q <= 1'b0;
         tx_valid_q      <= 1'b0;
         tx_start_q      <= 1'b0;
         tx_last_q       <= 1'b0;
         tx_bytes_q      <= '0;
         tx_data_q       <= '0;
         tx_vlan_q       <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            open_q    <= !rx_last;
            idx_q     <= (cur_idx == 3'd4) ? 3'd4 : cur_idx + 3'd1;
            decided_q <= decided_d;
         end
         if (rx_valid && rx_start) begin
            vlan_q          <= port_vlan;
            drop_tagged_q   <= port_drop_tagged;
            drop_untagged_q <= port_drop_untagged;
         end
         vf_wr_q  <= vf_wr_q + push_n;
         vf_rd_q  <= vf_rd_q + {1'b0, vf_pop};
         vf_cnt_q <= vf_cnt_q + {1'b0, push_n} - {2'b0, vf_pop};
         if (rd_pop) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            in_frame_q <= !head.last;
         end else if (close_frame) begin
            in_frame_q <= 1'b0;
         end
         tx_valid_q <= emit;
         tx_start_q <= emit && head.start;
         tx_last_q  <= emit && head.last;
         if (emit) begin
            tx_bytes_q <= head.bytes;
            tx_data_q  <= head.data;
            tx_vlan_q  <= vhead.vlan;
         end
      end
   end

   assign tx_valid       = tx_valid_q;
   assign tx_start       = tx_start_q;
   assign tx_last        = tx_last_q;
   assign tx_bytes_valid = tx_bytes_q;
   assign tx_data        = tx_data_q;
   assign tx_vlan        = tx_vlan_q;

`ifdef VLAN_INGRESS_COUNTERS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] n);
      logic [32:0] s;
      s = {1'b0, c} + {31'b0, n};
      return s[32] ? '1 : s[31:0];
   endfunction

   logic [1:0] inc_tag, inc_untag, inc_mal;
   assign inc_tag   = {1'b0, push_b && vb.drop && !malformed_b && vid_tagged};
   assign inc_untag = {1'b0, push_b && vb.drop && !malformed_b && !vid_tagged};
   assign inc_mal   = {1'b0, trunc} + {1'b0, push_b && malformed_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count_tagged    <= '0;
         drop_count_untagged  <= '0;
         drop_count_malformed <= '0;
      end else begin
         drop_count_tagged    <= sat_add(drop_count_tagged, inc_tag);
         drop_count_untagged  <= sat_add(drop_count_untagged, inc_untag);
         drop_count_malformed <= sat_add(drop_count_malformed, inc_mal);
      end
   end
`endif

`ifndef SYNTHESIS
   a_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && buf_full && !rd_pop));
   a_vf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, vf_cnt_q} + {2'b0, push_n}) <= (4'd4 + {3'b0, vf_pop}));
`endif

endmodule
